// File: rtl/edu_hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edu_hamming_pkg
// Brief    : Shared Hamming(7,4) types, bit map and encode function.
// Revision : 1.0  initial release
// ============================================================================
package edu_hamming_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] codeword_t;

   localparam int P1_BIT    = 0;
   localparam int P2_BIT    = 1;
   localparam int P4_BIT    = 3;
   localparam int D_BITS[4] = '{2, 4, 5, 6};

   // Also used by the receive-side corrector so both ends agree on the bit map.
   function automatic codeword_t hamming_enc(input nibble_t d);
      codeword_t c;
      c            = '0;
      c[D_BITS[0]] = d[0];
      c[D_BITS[1]] = d[1];
      c[D_BITS[2]] = d[2];
      c[D_BITS[3]] = d[3];
      c[P1_BIT]    = d[0] ^ d[1] ^ d[3];
      c[P2_BIT]    = d[0] ^ d[2] ^ d[3];
      c[P4_BIT]    = d[1] ^ d[2] ^ d[3];
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/edu_hamming_fifo.sv
`default_nettype none
// ============================================================================
// Module   : edu_hamming_fifo
// Brief    : Small ready/valid buffer; readiness depends on registered state only.
// Revision : 1.0  initial release
// ============================================================================
module edu_hamming_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_wr_data,
   input  logic         i_wr_valid,
   output logic         o_wr_ready,
   output logic [W-1:0] o_rd_data,
   output logic         o_rd_valid,
   input  logic         i_rd_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DEPTH);

   logic [W-1:0]     r_mem[DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_init;
   logic             w_wr;
   logic             w_rd;

   // r_init keeps the input side closed until the first edge after reset release.
   assign o_wr_ready = r_init & (r_count < c_FULL);
   assign o_rd_valid = (r_count != '0);
   assign o_rd_data  = r_mem[r_rd_ptr];
   assign w_wr       = i_wr_valid & o_wr_ready;
   assign w_rd       = o_rd_valid & i_rd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_init   <= 1'b0;
      end else begin
         r_init <= 1'b1;
         if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + 1'b1;
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/edu_hamming_encoder.sv
`default_nettype none
// ============================================================================
// Module   : edu_hamming_encoder
// Brief    : Buffered Hamming(7,4) encoder with periodic single-bit error injection.
// Revision : 1.0  initial release
// ============================================================================
module edu_hamming_encoder
   import edu_hamming_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int ERR_PERIOD = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [6:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_err,
   input  logic             err_inj_en,
   output logic [CNT_W-1:0] cw_count
);

   localparam int INJ_W = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
   localparam logic [INJ_W-1:0] c_INJ_LAST = INJ_W'(ERR_PERIOD - 1);
   localparam logic [2:0]       c_POS_LAST = 3'd6;

   logic [INJ_W-1:0] r_inj_cnt;
   logic [2:0]       r_err_pos;
   logic [CNT_W-1:0] r_cw_count;
   logic             w_accept;
   logic             w_pop;
   logic             w_inject;
   codeword_t        w_cw_clean;
   codeword_t        w_cw;
   logic [7:0]       w_wr_entry;
   logic [7:0]       w_rd_entry;

   assign w_accept   = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign w_inject   = err_inj_en & (r_inj_cnt == c_INJ_LAST);
   assign w_cw_clean = hamming_enc(in_data);
   assign w_cw       = w_inject ? (w_cw_clean ^ (codeword_t'(1) << r_err_pos)) : w_cw_clean;
   assign w_wr_entry = {w_inject, w_cw};

   edu_hamming_fifo #(
      .W     (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_data  (w_wr_entry),
      .i_wr_valid (in_valid),
      .o_wr_ready (in_ready),
      .o_rd_data  (w_rd_entry),
      .o_rd_valid (out_valid),
      .i_rd_ready (out_ready)
   );

   assign out_data = w_rd_entry[6:0];
   assign out_err  = w_rd_entry[7];
   assign cw_count = r_cw_count;

   // Injection state only moves on accepts taken while injection is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inj_cnt  <= '0;
         r_err_pos  <= '0;
         r_cw_count <= '0;
      end else begin
         if (w_accept && err_inj_en) begin
            if (w_inject) begin
               r_inj_cnt <= '0;
               r_err_pos <= (r_err_pos == c_POS_LAST) ? 3'd0 : r_err_pos + 3'd1;
            end else begin
               r_inj_cnt <= r_inj_cnt + 1'b1;
            end
         end
         if (w_pop) begin
            r_cw_count <= r_cw_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
